psc_trigger_packet_rx: RTL and testbench
========================================

Name: psc_trigger_packet_rx

Overview:
- Receive-side parser for the 10-byte PSC trigger/status frame carried over the 8b10b link.
- Consumes decoded byte and K-flag beats from the link decoder and validates frame structure.
- On a valid trigger frame, emits a one-cycle trigger pulse toward the PSC timing logic; on a valid status frame, emits a status pulse.
- Maintains frame-type and error counters and flags malformed frames for the status registers.

Parameters:
- SOP, 8'h3C, start-of-packet K character (K28.1).
- EOP, 8'hBC, end-of-packet K character (K28.5).
- TYPE_TRIGGER, 8'h70, byte-2 code for a trigger frame.
- TYPE_STATUS, 8'h40, byte-2 code for a status (non-trigger) frame.
- TIMEOUT, 32, maximum clock cycles allowed between accepted beats inside a frame.
- CNT_W, 16, width of the frame counters.

Ports:
- clk  input  1  block clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  decoded byte from the link decoder
- rx_is_k  input  1  1 = rx_data is a K character
- rx_valid  input  1  beat qualifier; a beat is accepted on each clk edge where this is high
- trigger_pulse  output  1  one-cycle pulse per valid trigger frame
- status_pulse  output  1  one-cycle pulse per valid status frame
- frame_error  output  1  one-cycle pulse per aborted or malformed frame
- busy  output  1  high while inside a frame (state != IDLE)
- trig_count  output  CNT_W  valid trigger frames received; wraps
- status_count  output  CNT_W  valid status frames received; wraps
- err_count  output  8  malformed frames; saturates at 8'hFF

Behaviour:
- Reset (async assert, synchronous release): state = IDLE, byte index = 0, all pulses = 0, busy = 0, all counters = 0, timeout counter = 0.
- Frame layout, indexed from 0:
  - byte 0: SOP with K=1.
  - byte 1: 8'h00, K=0.
  - byte 2: TYPE_TRIGGER or TYPE_STATUS, K=0.
  - bytes 3..8: 8'h00, K=0.
  - byte 9: EOP with K=1.
- States:
  - IDLE: an accepted SOP beat with K=1 -> PAYLOAD, index = 1, type/error flags cleared. All other beats are discarded silently with no error; this covers idle fill.
  - PAYLOAD (index 1..8): each accepted beat is checked against the layout.
    - Byte-2 value is latched.
    - A K=0 data mismatch sets a sticky bad-frame flag; reception continues to index 9.
    - A K=1 beat other than SOP aborts: frame_error pulse, -> IDLE.
    - SOP with K=1 mid-frame: counts as an error on the old frame (frame_error pulse), then restarts as a new frame with index = 1 and stays in PAYLOAD.
    - Index increments per accepted beat; after index 8 -> WAIT_EOP.
  - WAIT_EOP (index 9): on the accepted beat, return to IDLE.
    - EOP with K=1 and no bad flag: pulse per the latched type (trigger_pulse or status_pulse) and increment the matching counter.
    - Any other beat, or bad flag set: frame_error pulse.
    - SOP with K=1 here follows the same rule as mid-frame SOP: error, then restart.
- Latency: pulses and counter updates are registered and appear in the cycle after the clk edge that accepts the EOP or error beat. Exactly one of trigger_pulse / status_pulse / frame_error is high per frame outcome; never two at once.
- Timeout:
  - The timeout counter clears on every accepted beat and increments while busy and rx_valid = 0.
  - When it reaches TIMEOUT: frame_error pulse, -> IDLE.
  - Not active in IDLE.
- err_count increments on every frame_error pulse and saturates at 8'hFF. trig_count and status_count wrap modulo 2^CNT_W.
- Back-to-back frames with no idle beat between EOP and the next SOP are fully supported (EOP acceptance -> IDLE; the next cycle's SOP is accepted).
- rx_valid = 0 holds the state; no check is made on rx_data or rx_is_k.
- rst_n asserted mid-frame: immediate return to reset values; no pulse is emitted for the partial frame.

Test Plan:
- Trigger frame: 3C(K),00,70,00,00,00,00,00,00,BC(K) on consecutive cycles -> trigger_pulse high for 1 cycle, one cycle after the EOP beat; trig_count = 1; err_count = 0.
- Status frame followed back-to-back by a trigger frame, with rx_valid gaps of 3 cycles between beats -> status_pulse, then trigger_pulse; status_count = 1, trig_count = 1; busy low only between frames.
- Byte 5 = 8'h01 in a trigger frame -> no trigger_pulse; frame_error pulses after EOP; err_count = 1. Byte 2 = 8'h55 -> same result.
- SOP at index 4, then a full valid trigger frame from that SOP onward -> one frame_error plus one trigger_pulse; err_count = 1, trig_count = 1.
- Frame stalled after byte 3 with rx_valid = 0 for 32 cycles -> frame_error on the timeout; busy = 0. A following valid frame is received normally.
- rst_n pulsed low at index 6 -> all outputs and counters return to 0 asynchronously; 300 malformed frames -> err_count holds at 8'hFF.

Source files
------------

// File: rtl/psc_trigger_packet_rx.sv
// ---------------------------------------------------------------------------
// psc_trigger_packet_rx
// Receive-side parser for the 10-byte PSC trigger/status frame. Decoded
// byte/K beats from the 8b10b link decoder are checked against the frame
// layout, and a one-cycle pulse is emitted for each frame outcome.
//
// Frame layout (index: content):
//   0: SOP (K)   1: 00   2: TYPE_TRIGGER/TYPE_STATUS   3..8: 00   9: EOP (K)
//
// Ports:
//   clk           block clock
//   rst_n         asynchronous active-low reset
//   rx_data       decoded byte from the link decoder
//   rx_is_k       1 = rx_data is a K character
//   rx_valid      beat qualifier
//   trigger_pulse one-cycle pulse per valid trigger frame
//   status_pulse  one-cycle pulse per valid status frame
//   frame_error   one-cycle pulse per aborted, malformed or timed-out frame
//   busy          high while inside a frame
//   trig_count    valid trigger frames (wraps)
//   status_count  valid status frames (wraps)
//   err_count     frame errors (saturates at 8'hFF)
//
// state    | meaning
// IDLE     | waiting for SOP; all other beats silently dropped
// PAYLOAD  | receiving bytes 1..8, checking each against the layout
// WAIT_EOP | expecting EOP at byte 9, then reporting the outcome
// ---------------------------------------------------------------------------
module psc_trigger_packet_rx #(
  parameter logic [7:0] SOP          = 8'h3C,
  parameter logic [7:0] EOP          = 8'hBC,
  parameter logic [7:0] TYPE_TRIGGER = 8'h70,
  parameter logic [7:0] TYPE_STATUS  = 8'h40,
  parameter int         TIMEOUT      = 32,
  parameter int         CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_is_k,
  input  logic             rx_valid,
  output logic             trigger_pulse,
  output logic             status_pulse,
  output logic             frame_error,
  output logic             busy,
  output logic [CNT_W-1:0] trig_count,
  output logic [CNT_W-1:0] status_count,
  output logic [7:0]       err_count
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, WAIT_EOP} state_t;

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [7:0]       type_q;
  logic             bad_q;
  logic [TMO_W-1:0] tmo_q;
  logic             trig_q, stat_q, err_q;
  logic [CNT_W-1:0] trig_cnt_q, stat_cnt_q;
  logic [7:0]       err_cnt_q;

  logic is_sop, is_eop, data_ok;
  logic ev_trig_d, ev_stat_d, ev_err_d;

  assign is_sop = rx_is_k && (rx_data == SOP);
  assign is_eop = rx_is_k && (rx_data == EOP);

  // Byte 2 carries the frame type; every other payload byte must be zero.
  assign data_ok = (idx_q == 4'd2) ? ((rx_data == TYPE_TRIGGER) || (rx_data == TYPE_STATUS))
                                   : (rx_data == 8'h00);

  // Frame outcome for the current edge; at most one event is ever set.
  always_comb begin
    ev_trig_d = 1'b0;
    ev_stat_d = 1'b0;
    ev_err_d  = 1'b0;
    if (state_q != IDLE) begin
      if (rx_valid) begin
        if (is_sop) begin
          ev_err_d = 1'b1;
        end else if (state_q == WAIT_EOP) begin
          if (is_eop && !bad_q) begin
            // bad_q is clear, so byte 2 was one of the two legal types
            if (type_q == TYPE_TRIGGER) ev_trig_d = 1'b1;
            else                        ev_stat_d = 1'b1;
          end else begin
            ev_err_d = 1'b1;
          end
        end else if (rx_is_k) begin
          ev_err_d = 1'b1;
        end
      end else if (tmo_q == TMO_LAST) begin
        ev_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      type_q     <= '0;
      bad_q      <= 1'b0;
      tmo_q      <= '0;
      trig_q     <= 1'b0;
      stat_q     <= 1'b0;
      err_q      <= 1'b0;
      trig_cnt_q <= '0;
      stat_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      trig_q <= ev_trig_d;
      stat_q <= ev_stat_d;
      err_q  <= ev_err_d;
      if (ev_trig_d) trig_cnt_q <= trig_cnt_q + CNT_W'(1);
      if (ev_stat_d) stat_cnt_q <= stat_cnt_q + CNT_W'(1);
      if (ev_err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;

      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (rx_valid && is_sop) begin
            state_q <= PAYLOAD;
            idx_q   <= 4'd1;
            type_q  <= '0;
            bad_q   <= 1'b0;
          end
        end
        PAYLOAD, WAIT_EOP: begin
          if (rx_valid) begin
            tmo_q <= '0;
            if (is_sop) begin
              // old frame already flagged above; this SOP opens a new one
              state_q <= PAYLOAD;
              idx_q   <= 4'd1;
              type_q  <= '0;
              bad_q   <= 1'b0;
            end else if ((state_q == WAIT_EOP) || rx_is_k) begin
              state_q <= IDLE;
              idx_q   <= '0;
            end else begin
              if (idx_q == 4'd2) type_q <= rx_data;
              if (!data_ok)      bad_q  <= 1'b1;
              idx_q <= idx_q + 4'd1;
              if (idx_q == 4'd8) state_q <= WAIT_EOP;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trigger_pulse = trig_q;
  assign status_pulse  = stat_q;
  assign frame_error   = err_q;
  assign busy          = (state_q != IDLE);
  assign trig_count    = trig_cnt_q;
  assign status_count  = stat_cnt_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_psc_trigger_packet_rx.sv
module tb_psc_trigger_packet_rx;

  localparam logic [7:0] SOP = 8'h3C;
  localparam logic [7:0] EOP = 8'hBC;
  localparam logic [7:0] TT  = 8'h70;
  localparam logic [7:0] TS  = 8'h40;
  localparam int TIMEOUT = 32;

  logic        clk, rst_n;
  logic [7:0]  rx_data;
  logic        rx_is_k, rx_valid;
  logic        trigger_pulse, status_pulse, frame_error, busy;
  logic [15:0] trig_count, status_count;
  logic [7:0]  err_count;

  psc_trigger_packet_rx dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_is_k(rx_is_k), .rx_valid(rx_valid),
    .trigger_pulse(trigger_pulse), .status_pulse(status_pulse),
    .frame_error(frame_error), .busy(busy),
    .trig_count(trig_count), .status_count(status_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: collects the beats of a frame and judges the whole
  // frame against the layout once ten beats are in.
  bit         m_in;
  int         m_len, m_idle;
  logic [8:0] m_buf [10];
  int         m_tp, m_sp, m_fe, m_ct, m_cs, m_ce;

  logic [8:0] fr [10];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_len = 0; m_idle = 0;
    m_tp = 0; m_sp = 0; m_fe = 0;
    m_ct = 0; m_cs = 0; m_ce = 0;
  endtask

  task automatic model_err();
    m_fe = 1;
    if (m_ce < 255) m_ce++;
  endtask

  task automatic model_edge(input logic [7:0] d, input logic k, input logic v);
    logic ok;
    m_tp = 0; m_sp = 0; m_fe = 0;
    if (!m_in) begin
      if (v && k && d == SOP) begin m_in = 1; m_len = 1; m_idle = 0; end
    end else if (v) begin
      m_idle = 0;
      if (k && d == SOP) begin
        model_err(); m_len = 1;
      end else if (k && m_len < 9) begin
        model_err(); m_in = 0;
      end else begin
        m_buf[m_len] = {k, d};
        m_len++;
        if (m_len == 10) begin
          m_in = 0;
          ok = (m_buf[9] == {1'b1, EOP});
          for (int i = 1; i < 9; i++) begin
            if (i == 2) ok &= (m_buf[2] == {1'b0, TT}) || (m_buf[2] == {1'b0, TS});
            else        ok &= (m_buf[i] == 9'h000);
          end
          if (!ok)                      model_err();
          else if (m_buf[2][7:0] == TT) begin m_tp = 1; m_ct = (m_ct + 1) & 16'hFFFF; end
          else                          begin m_sp = 1; m_cs = (m_cs + 1) & 16'hFFFF; end
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin model_err(); m_in = 0; end
    end
  endtask

  task automatic compare_all();
    check_eq("trigger_pulse", 32'(trigger_pulse), m_tp);
    check_eq("status_pulse",  32'(status_pulse),  m_sp);
    check_eq("frame_error",   32'(frame_error),   m_fe);
    check_eq("busy",          32'(busy),          32'(m_in));
    check_eq("trig_count",    32'(trig_count),    m_ct);
    check_eq("status_count",  32'(status_count),  m_cs);
    check_eq("err_count",     32'(err_count),     m_ce);
  endtask

  // Called at posedge+1; drives a beat, lets one edge pass, then checks.
  task automatic step(input logic [8:0] b, input logic v);
    rx_data  = b[7:0];
    rx_is_k  = b[8];
    rx_valid = v;
    model_edge(b[7:0], b[8], v);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(9'($urandom), 1'b0);
  endtask

  task automatic build_frame(input logic [7:0] typ);
    fr[0] = {1'b1, SOP};
    for (int i = 1; i < 9; i++) fr[i] = 9'h000;
    fr[2] = {1'b0, typ};
    fr[9] = {1'b1, EOP};
  endtask

  task automatic send_beats(input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      if (i != first) idle(gap);
      step(fr[i], 1'b1);
    end
  endtask

  task automatic send_frame(input int gap);
    send_beats(0, 9, gap);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_is_k = 1'b0; rx_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // single trigger frame on consecutive cycles
    build_frame(TT); send_frame(0);
    idle(2);
    // status then trigger, back-to-back, 3-cycle gaps between beats
    build_frame(TS); send_frame(3);
    build_frame(TT); send_frame(3);
    idle(2);
    // bad payload byte, then bad type byte
    build_frame(TT); fr[5] = 9'h001; send_frame(0);
    build_frame(8'h55); send_frame(1);
    // SOP at index 4 restarts a frame
    build_frame(TT); send_beats(0, 3, 0); send_frame(0);
    // 31-cycle stall survives, 32-cycle stall times out
    build_frame(TS); send_beats(0, 3, 0); idle(TIMEOUT - 1); send_beats(4, 9, 0);
    build_frame(TT); send_beats(0, 3, 0); idle(TIMEOUT);
    send_frame(0);
    // K abort mid-frame, and wrong K at EOP position
    build_frame(TT); fr[6] = {1'b1, EOP}; send_frame(0);
    build_frame(TS); fr[9] = {1'b1, 8'h1C}; send_frame(0);

    // randomized frames with occasional corruption and stalls
    for (int f = 0; f < 200; f++) begin
      int gap, p, pick;
      build_frame(($urandom_range(0, 1) == 1) ? TT : TS);
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(1, 9);
        pick = $urandom_range(0, 5);
        case (pick)
          0: fr[p] = 9'h000;
          1: fr[p] = {1'b0, TT};
          2: fr[p] = {1'b1, SOP};
          3: fr[p] = {1'b1, EOP};
          4: fr[p] = {1'b0, 8'($urandom)};
          default: fr[p] = 9'($urandom);
        endcase
      end
      gap = ($urandom_range(0, 19) == 0) ? $urandom_range(30, 34) : $urandom_range(0, 2);
      send_frame(gap);
      for (int j = $urandom_range(0, 2); j > 0; j--)
        step({($urandom_range(0, 3) == 0), 8'($urandom)}, $urandom_range(0, 1) == 1);
    end

    // asynchronous reset in the middle of a frame
    build_frame(TT); send_beats(0, 5, 0);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_eq("rst_busy",       32'(busy), 0);
    check_eq("rst_err_count",  32'(err_count), 0);
    check_eq("rst_trig_count", 32'(trig_count), 0);
    check_eq("rst_trigger",    32'(trigger_pulse), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    compare_all();

    // 300 aborted frames saturate the error counter
    for (int f = 0; f < 300; f++) begin
      step({1'b1, SOP}, 1'b1);
      step({1'b1, EOP}, 1'b1);
    end
    check_eq("err_count_sat", 32'(err_count), 32'h0000_00FF);
    build_frame(TT); send_frame(0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
